// File: rtl/fs4_tdm_mixer.sv
// Per-channel fs/4 and fs/2 I/Q rotator for TDM streams.
// Registered output stage with a one-entry skid buffer keeps full throughput under backpressure.
module fs4_tdm_mixer #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned NUM_CH     = 4,
    parameter int unsigned SATURATE   = 1,
    parameter int unsigned CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                         clk_i,
    input  logic                         reset_ni,
    input  logic                         valid_i,
    output logic                         ready_o,
    input  logic signed [DATA_WIDTH-1:0] I_i,
    input  logic signed [DATA_WIDTH-1:0] Q_i,
    input  logic [CH_W-1:0]              ch_i,
    input  logic [1:0]                   mode_i,
    input  logic [NUM_CH-1:0]            dir_i,
    input  logic                         phase_clr_i,
    output logic                         valid_o,
    input  logic                         ready_i,
    output logic signed [DATA_WIDTH-1:0] I_o,
    output logic signed [DATA_WIDTH-1:0] Q_o,
    output logic [CH_W-1:0]              ch_o,
    output logic [1:0]                   phase_o
);

    localparam int unsigned DW = DATA_WIDTH;
    localparam logic signed [DW-1:0] MIN_V = {1'b1, {(DW-1){1'b0}}};
    localparam logic signed [DW-1:0] MAX_V = {1'b0, {(DW-1){1'b1}}};

    typedef struct packed {
        logic [DW-1:0]   i;
        logic [DW-1:0]   q;
        logic [CH_W-1:0] ch;
        logic [1:0]      ph;
    } beat_t;

    function automatic logic signed [DW-1:0] neg(input logic signed [DW-1:0] x);
        if ((SATURATE != 0) && (x == MIN_V)) begin
            return MAX_V;
        end
        return -x;
    endfunction

    logic [1:0] cntr_q [NUM_CH];
    logic [1:0] cntr_d [NUM_CH];
    beat_t      out_q, out_d, skid_q, skid_d, beat_in;
    logic       out_valid_q, out_valid_d;
    logic       skid_valid_q, skid_valid_d;
    logic       ready_q, ready_d;
    logic       accept, in_range;
    logic [1:0] p, rot_sel;
    logic signed [DW-1:0] rot_i, rot_q;

    assign accept = valid_i && ready_q;

    // Look up the channel's phase; out-of-range channels leave in_range low.
    always_comb begin
        in_range = 1'b0;
        p        = 2'd0;
        for (int unsigned c = 0; c < NUM_CH; c++) begin
            if (ch_i == CH_W'(c)) begin
                in_range = 1'b1;
                p        = cntr_q[c];
            end
        end
    end

    always_comb begin
        rot_sel = 2'd0;
        if (in_range) begin
            case (mode_i)
                2'b01:   rot_sel = p;
                2'b10:   rot_sel = {p[0], 1'b0};
                default: rot_sel = 2'd0;
            endcase
        end
    end

    always_comb begin
        rot_i = I_i;
        rot_q = Q_i;
        case (rot_sel)
            2'd1: begin rot_i = neg(Q_i); rot_q = I_i;      end
            2'd2: begin rot_i = neg(I_i); rot_q = neg(Q_i); end
            2'd3: begin rot_i = Q_i;      rot_q = neg(I_i); end
            default: ;
        endcase
    end

    always_comb begin
        beat_in.i  = rot_i;
        beat_in.q  = rot_q;
        beat_in.ch = ch_i;
        beat_in.ph = in_range ? p : 2'd0;
    end

    // Phase step on every accepted in-range beat; a clear overrides it.
    always_comb begin
        for (int unsigned c = 0; c < NUM_CH; c++) begin
            cntr_d[c] = cntr_q[c];
            if (accept && (ch_i == CH_W'(c))) begin
                cntr_d[c] = dir_i[c] ? (cntr_q[c] + 2'd1) : (cntr_q[c] - 2'd1);
            end
            if (phase_clr_i) begin
                cntr_d[c] = 2'd0;
            end
        end
    end

    // Output/skid staging: skid drains first so order is kept.
    always_comb begin
        out_d        = out_q;
        out_valid_d  = out_valid_q;
        skid_d       = skid_q;
        skid_valid_d = skid_valid_q;
        if (!out_valid_q || ready_i) begin
            if (skid_valid_q) begin
                out_d        = skid_q;
                out_valid_d  = 1'b1;
                skid_valid_d = 1'b0;
            end else begin
                out_valid_d = accept;
                if (accept) begin
                    out_d = beat_in;
                end
            end
        end else if (accept) begin
            skid_d       = beat_in;
            skid_valid_d = 1'b1;
        end
        ready_d = !skid_valid_d;
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            out_q        <= '0;
            skid_q       <= '0;
            out_valid_q  <= 1'b0;
            skid_valid_q <= 1'b0;
            ready_q      <= 1'b0;
            for (int unsigned c = 0; c < NUM_CH; c++) begin
                cntr_q[c] <= 2'd0;
            end
        end else begin
            out_q        <= out_d;
            skid_q       <= skid_d;
            out_valid_q  <= out_valid_d;
            skid_valid_q <= skid_valid_d;
            ready_q      <= ready_d;
            for (int unsigned c = 0; c < NUM_CH; c++) begin
                cntr_q[c] <= cntr_d[c];
            end
        end
    end

    assign ready_o = ready_q;
    assign valid_o = out_valid_q;
    assign I_o     = out_q.i;
    assign Q_o     = out_q.q;
    assign ch_o    = out_q.ch;
    assign phase_o = out_q.ph;

endmodule
